sqrt_seg_engine: RTL and testbench

SQRT_SEG_ENGINE -- requirements
Module: sqrt_seg_engine

---
 rtl/sqrt_seg_pkg.sv | 22 ++
 rtl/hex_seg7.sv | 12 +
 rtl/sqrt_seg_engine.sv | 171 +++++++++++++++++
 tb/tb_sqrt_seg_engine.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sqrt_seg_pkg.sv
// Shared types and display constants for the square-root seven-segment engine.
// Optional build macro SQRT_SEG_ZERO_BLANK_EN is consumed by sqrt_seg_engine.
package sqrt_seg_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    localparam logic [6:0] GLYPH_P     = 7'b1110011;
    localparam logic [6:0] GLYPH_Q     = 7'b1100111;
    localparam logic [6:0] GLYPH_BLANK = 7'b0000000;

    // Segment order {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

endpackage

// File: rtl/hex_seg7.sv
// 4-bit hex digit to 7-segment decode.
// Pure combinational lookup into the shared table.
module hex_seg7
    import sqrt_seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nib];

endmodule

// File: rtl/sqrt_seg_engine.sv
// Sequential restoring square root with a paged seven-segment readout.
// Define SQRT_SEG_ZERO_BLANK_EN to blank leading zero nibbles of root/rem.
module sqrt_seg_engine
    import sqrt_seg_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ROOT_W = DATA_W / 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              next,
    input  logic [DATA_W-1:0] din,
    output logic              busy,
    output logic              done,
    output logic [ROOT_W-1:0] root,
    output logic [ROOT_W:0]   rem,
    output logic [3:0]        pos,
    output logic [6:0]        seg
);

    localparam int RN   = (ROOT_W + 3) / 4;
    localparam int QN   = (ROOT_W + 4) / 4;
    localparam int LAST = RN + 1 + QN;
    localparam int CW   = $clog2(ROOT_W + 1);

    state_t              state;
    logic                start_q;
    logic                next_q;
    logic                start_edge;
    logic                next_edge;
    logic [DATA_W-1:0]   rad;
    logic [ROOT_W:0]     rem_acc;
    logic [ROOT_W-1:0]   root_acc;
    logic [CW-1:0]       cnt;

    logic [ROOT_W+2:0]   part;
    logic [ROOT_W+2:0]   trial;
    logic [ROOT_W+2:0]   diff;
    logic                fits;
    logic [ROOT_W:0]     rem_nx;
    logic [ROOT_W-1:0]   root_nx;

    logic [RN*4-1:0]     root_pad;
    logic [QN*4-1:0]     rem_pad;
    logic                in_root;
    logic                in_rem;
    logic                blank;
    logic [3:0]          nib;
    logic [6:0]          hex_seg;
    int                  idx;

    assign start_edge = start & ~start_q;
    assign next_edge  = next & ~next_q;

    // Button history for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q <= 1'b0;
            next_q  <= 1'b0;
        end else begin
            start_q <= start;
            next_q  <= next;
        end
    end

    // One restoring step: bring down two radicand bits, try subtracting 4*root+1.
    always_comb begin
        part    = {rem_acc, rad[DATA_W-1 -: 2]};
        trial   = {1'b0, root_acc, 2'b01};
        fits    = (part >= trial);
        diff    = part - trial;
        rem_nx  = fits ? diff[ROOT_W:0] : part[ROOT_W:0];
        root_nx = {root_acc[ROOT_W-2:0], fits};
    end

    // Control FSM, datapath registers, results and display position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            root     <= '0;
            rem      <= '0;
            pos      <= '0;
            rad      <= '0;
            rem_acc  <= '0;
            root_acc <= '0;
            cnt      <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_edge) begin
                        rad      <= din;
                        rem_acc  <= '0;
                        root_acc <= '0;
                        cnt      <= CW'(ROOT_W - 1);
                        busy     <= 1'b1;
                        state    <= CALC;
                    end else if (next_edge) begin
                        if (pos == 4'(LAST))
                            pos <= '0;
                        else
                            pos <= pos + 4'd1;
                    end
                end
                CALC: begin
                    rad      <= rad << 2;
                    rem_acc  <= rem_nx;
                    root_acc <= root_nx;
                    if (cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        root  <= root_nx;
                        rem   <= rem_nx;
                        pos   <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pick the nibble shown at the current position, MS nibble first.
    always_comb begin
        root_pad             = '0;
        root_pad[ROOT_W-1:0] = root;
        rem_pad              = '0;
        rem_pad[ROOT_W:0]    = rem;
        in_root = (int'(pos) >= 1) && (int'(pos) <= RN);
        in_rem  = (int'(pos) >= RN + 2) && (int'(pos) <= LAST);
        idx     = 0;
        nib     = 4'd0;
        blank   = 1'b0;
        if (in_root) begin
            idx = RN - int'(pos);
            nib = root_pad[idx*4 +: 4];
`ifdef SQRT_SEG_ZERO_BLANK_EN
            blank = (idx != 0) && ((root_pad >> (idx * 4)) == '0);
`endif
        end else if (in_rem) begin
            idx = LAST - int'(pos);
            nib = rem_pad[idx*4 +: 4];
`ifdef SQRT_SEG_ZERO_BLANK_EN
            blank = (idx != 0) && ((rem_pad >> (idx * 4)) == '0);
`endif
        end
    end

    hex_seg7 u_hex (
        .nib (nib),
        .seg (hex_seg)
    );

    // Final glyph selection for the display.
    always_comb begin
        if (pos == 4'd0)
            seg = GLYPH_P;
        else if (int'(pos) == RN + 1)
            seg = GLYPH_Q;
        else if ((in_root || in_rem) && !blank)
            seg = hex_seg;
        else
            seg = GLYPH_BLANK;
    end

endmodule

// File: tb/tb_sqrt_seg_engine.sv
// Directed self-checking bench for sqrt_seg_engine (DATA_W=16).
// Honours SQRT_SEG_ZERO_BLANK_EN for the display expectations.
module tb_sqrt_seg_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        next = 1'b0;
    logic [15:0] din = '0;
    logic        busy;
    logic        done;
    logic [7:0]  root;
    logic [8:0]  rem;
    logic [3:0]  pos;
    logic [6:0]  seg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sqrt_seg_engine dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .next  (next),
        .din   (din),
        .busy  (busy),
        .done  (done),
        .root  (root),
        .rem   (rem),
        .pos   (pos),
        .seg   (seg)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start edge at edge 0; returns cycle index where done was seen.
    task automatic do_calc(input logic [15:0] v,
                           output int cyc, output bit busy_ok);
        din   = v;
        start = 1'b1;
        tick();
        start   = 1'b0;
        cyc     = 1;
        busy_ok = 1'b1;
        while (!done && cyc < 40) begin
            if (!busy) busy_ok = 1'b0;
            tick();
            cyc++;
        end
        if (busy) busy_ok = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({busy, done, root, rem, pos} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b done=%b root=%h rem=%h pos=%0d want 0",
                     busy, done, root, rem, pos);
        end
        checks++;
        if (seg !== 7'b1110011) begin
            errors++;
            $display("FAIL reset_seg got %b want 1110011", seg);
        end
        #2 rst = 1'b0;
        tick();
    endtask

    task automatic test_calc(input logic [15:0] v,
                             input logic [7:0] er, input logic [8:0] eq);
        int cyc;
        bit bok;
        do_calc(v, cyc, bok);
        checks++;
        if (cyc !== 9 || done !== 1'b1) begin
            errors++;
            $display("FAIL done_cycle din=%h got cycle %0d done=%b want 9/1", v, cyc, done);
        end
        checks++;
        if (!bok) begin
            errors++;
            $display("FAIL busy_window din=%h got busy wrong want high 1..8 only", v);
        end
        checks++;
        if (root !== er || rem !== eq) begin
            errors++;
            $display("FAIL result din=%h got root=%h rem=%h want root=%h rem=%h",
                     v, root, rem, er, eq);
        end
        tick();
        checks++;
        if (done !== 1'b0 || root !== er) begin
            errors++;
            $display("FAIL done_pulse got done=%b root=%h want 0 %h", done, root, er);
        end
    endtask

    task automatic test_display();
        logic [3:0] ep [7] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd0};
`ifdef SQRT_SEG_ZERO_BLANK_EN
        logic [6:0] es [7] = '{7'b0000000, 7'b1111001, 7'b1100111,
                               7'b0000000, 7'b0000000, 7'b1100110,
                               7'b1110011};
`else
        logic [6:0] es [7] = '{7'b0111111, 7'b1111001, 7'b1100111,
                               7'b0111111, 7'b0111111, 7'b1100110,
                               7'b1110011};
`endif
        for (int i = 0; i < 7; i++) begin
            next = 1'b1;
            tick();
            next = 1'b0;
            tick();
            checks++;
            if (pos !== ep[i] || seg !== es[i]) begin
                errors++;
                $display("FAIL display step %0d got pos=%0d seg=%b want pos=%0d seg=%b",
                         i, pos, seg, ep[i], es[i]);
            end
        end
    endtask

    task automatic test_start_held();
        int n = 0;
        din   = 16'd81;
        start = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done) n++;
        end
        start = 1'b0;
        tick();
        checks++;
        if (n !== 1 || root !== 8'd9 || rem !== 9'd0) begin
            errors++;
            $display("FAIL start_held got dones=%0d root=%h rem=%h want 1 09 000", n, root, rem);
        end
    endtask

    task automatic test_start_busy();
        int n = 0;
        din   = 16'd200;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        din   = 16'hFFFF;
        start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) n++;
        end
        start = 1'b0;
        tick();
        checks++;
        if (n !== 1 || root !== 8'd14 || rem !== 9'd4 || busy !== 1'b0) begin
            errors++;
            $display("FAIL start_busy got dones=%0d root=%h rem=%h busy=%b want 1 0e 004 0",
                     n, root, rem, busy);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        din   = 16'd1000;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, root, rem, pos} !== '0) begin
            errors++;
            $display("FAIL reset_mid got busy=%b done=%b root=%h rem=%h pos=%0d want 0",
                     busy, done, root, rem, pos);
        end
        tick();
        #2 rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) n++;
        end
        checks++;
        if (n !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_nodone got dones=%0d busy=%b want 0 0", n, busy);
        end
        test_calc(16'd1000, 8'd31, 9'd39);
    endtask

    task automatic test_simul();
        int cyc;
        bit bok;
        next = 1'b1;
        tick();
        next = 1'b0;
        tick();
        next = 1'b1;
        tick();
        next = 1'b0;
        tick();
        checks++;
        if (pos !== 4'd2) begin
            errors++;
            $display("FAIL simul_pre got pos=%0d want 2", pos);
        end
        din   = 16'd49;
        start = 1'b1;
        next  = 1'b1;
        tick();
        start = 1'b0;
        next  = 1'b0;
        checks++;
        if (busy !== 1'b1 || pos !== 4'd2) begin
            errors++;
            $display("FAIL simul_edge got busy=%b pos=%0d want 1 2", busy, pos);
        end
        next = 1'b1;
        tick();
        next = 1'b0;
        tick();
        checks++;
        if (pos !== 4'd2) begin
            errors++;
            $display("FAIL next_busy got pos=%0d want 2", pos);
        end
        cyc = 3;
        bok = 1'b1;
        while (!done && cyc < 40) begin
            tick();
            cyc++;
        end
        checks++;
        if (done !== 1'b1 || cyc !== 9 || pos !== 4'd0 || root !== 8'd7 || rem !== 9'd0) begin
            errors++;
            $display("FAIL simul_done got done=%b cyc=%0d pos=%0d root=%h rem=%h want 1 9 0 07 000",
                     done, cyc, pos, root, rem);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_calc(16'd200, 8'd14, 9'd4);
        test_display();
        test_calc(16'd0, 8'd0, 9'd0);
        test_calc(16'hFFFF, 8'hFF, 9'h1FE);
        test_start_held();
        test_start_busy();
        test_reset_mid();
        test_simul();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
